// File: rtl/mac_stop_pkg.sv
// Shared types for the MAC-stop sequencer: FSM states, the (i,j,k,valid) tuple and index widths.
// The matrix dimensions here set the tuple field widths and must match the top-level M/K/N.
package mac_stop_pkg;
  localparam int M_DIM = 4;
  localparam int K_DIM = 4;
  localparam int N_DIM = 4;

  localparam int I_W = (M_DIM > 1) ? $clog2(M_DIM) : 1;
  localparam int K_W = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int J_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [I_W-1:0] i;
    logic [J_W-1:0] j;
    logic [K_W-1:0] k;
    logic           vld;
  } tuple_t;
endpackage

// File: rtl/mac_stop_align_pipe.sv
// STAGES-deep shift register of index tuples with a global hold; reset flushes only the valid bits.
module mac_stop_align_pipe
  import mac_stop_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  tuple_t din,
  output tuple_t dout
);

  tuple_t            data_p [STAGES];
  logic [STAGES-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (!hold) begin
      data_p[0] <= din;
      for (int s = 1; s < STAGES; s++) data_p[s] <= data_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (!hold) begin
      vld_p[0] <= din.vld;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_comb begin
    dout     = data_p[STAGES-1];
    dout.vld = vld_p[STAGES-1];
  end

endmodule

// File: rtl/mac_stop_seq.sv
// MAC-stop sequencer: walks (i,j,k), issues SRAM reads and delivers aligned indices to the accumulate slice.
// Optional perf counters are enabled with `define MAC_STOP_SEQ_PERF_EN.
module mac_stop_seq
  import mac_stop_pkg::*;
#(
  parameter int M        = M_DIM,
  parameter int K        = K_DIM,
  parameter int N        = N_DIM,
  parameter int READ_LAT = 1,
  parameter int MULT_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stall,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [I_W-1:0] a_row_addr,
  output logic [K_W-1:0] a_col_addr,
  output logic [K_W-1:0] b_row_addr,
  output logic [J_W-1:0] b_col_addr,
  output logic [I_W-1:0] matrix_a_row_addr_counter_reg,
  output logic [K_W-1:0] matrix_a_col_addr_counter_reg,
  output logic [K_W-1:0] matrix_b_row_addr_counter_reg,
  output logic [J_W-1:0] matrix_b_col_addr_counter_reg,
  output logic           mult_done_reg,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stalls
);

  localparam int PIPE = READ_LAT + MULT_LAT;
  localparam int CW   = $clog2(PIPE + 1);

  state_t          state, state_nxt;
  logic [I_W-1:0]  i;
  logic [J_W-1:0]  j;
  logic [K_W-1:0]  k;
  logic [CW-1:0]   drain_cnt;
  logic            issue, last_issue, aligned;
  tuple_t          push, tail;

  assign issue      = (state == RUN) && !stall;
  assign last_issue = issue && (i == I_W'(M-1)) && (j == J_W'(N-1)) && (k == K_W'(K-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (!stall && drain_cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (!stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // k innermost, carrying into j and then i; the final issue wraps all three back to 0.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (issue) begin
      if (k == K_W'(K-1)) begin
        k <= '0;
        if (j == J_W'(N-1)) begin
          j <= '0;
          i <= (i == I_W'(M-1)) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           drain_cnt <= '0;
    else if (last_issue)                 drain_cnt <= CW'(PIPE);
    else if (state == DRAIN && !stall)   drain_cnt <= drain_cnt - 1'b1;
  end

  assign push = '{i: i, j: j, k: k, vld: issue};

  mac_stop_align_pipe #(.STAGES(PIPE)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .hold  (stall),
    .din   (push),
    .dout  (tail)
  );

  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !stall;
  assign rd_en      = issue;
  assign a_row_addr = i;
  assign a_col_addr = k;
  assign b_row_addr = k;
  assign b_col_addr = j;

  // Invalid slots show index 0 so the accumulator's b_row==K-1 trigger cannot fire spuriously.
  assign aligned                       = tail.vld && !stall;
  assign mult_done_reg                 = aligned;
  assign matrix_a_row_addr_counter_reg = aligned ? tail.i : '0;
  assign matrix_a_col_addr_counter_reg = aligned ? tail.k : '0;
  assign matrix_b_row_addr_counter_reg = aligned ? tail.k : '0;
  assign matrix_b_col_addr_counter_reg = aligned ? tail.j : '0;

`ifdef MAC_STOP_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (busy) begin
      if (perf_cycles != '1)          perf_cycles <= perf_cycles + 1'b1;
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_mac_stop_seq.sv
// Bench for mac_stop_seq: job-progress model (count of unstalled cycles since start) checked every cycle,
// plus literal timing/index expectations for the directed jobs.
module tb_mac_stop_seq;
  localparam int M = 4, K = 4, N = 4, PIPE = 2;
  localparam int TOT = M * N * K;
  localparam int FIN = TOT + PIPE;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic        busy, done, rd_en, mult_done_reg;
  logic [1:0]  a_row_addr, a_col_addr, b_row_addr, b_col_addr;
  logic [1:0]  al_a_row, al_a_col, al_b_row, al_b_col;
  logic [31:0] perf_cycles, perf_stalls;

  mac_stop_seq dut (
    .clk                           (clk),
    .reset                         (reset),
    .start                         (start),
    .stall                         (stall),
    .busy                          (busy),
    .done                          (done),
    .rd_en                         (rd_en),
    .a_row_addr                    (a_row_addr),
    .a_col_addr                    (a_col_addr),
    .b_row_addr                    (b_row_addr),
    .b_col_addr                    (b_col_addr),
    .matrix_a_row_addr_counter_reg (al_a_row),
    .matrix_a_col_addr_counter_reg (al_a_col),
    .matrix_b_row_addr_counter_reg (al_b_row),
    .matrix_b_col_addr_counter_reg (al_b_col),
    .mult_done_reg                 (mult_done_reg),
    .perf_cycles                   (perf_cycles),
    .perf_stalls                   (perf_stalls)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Tuple n of the iteration order, encoded as i*100 + j*10 + k.
  function automatic int tup(input int n);
    return (n / (N * K)) * 100 + ((n / K) % N) * 10 + (n % K);
  endfunction

  bit busy_m = 1'b0;
  int act = 0, pc = 0, ps = 0, start_cyc = 0;
  int done_rel, first_rd, last_rd, first_md, last_md, last_busy, a5, al66;

  always @(negedge clk) begin
    int rel, e_addr, e_al, d_addr, d_al;
    bit e_rd, e_md, e_done;
    cyc++;
    rel    = cyc - start_cyc;
    d_addr = int'(a_row_addr) * 100 + int'(b_col_addr) * 10 + int'(a_col_addr);
    d_al   = int'(al_a_row) * 100 + int'(al_b_col) * 10 + int'(al_a_col);
    if (busy_m) begin
      if (rd_en) begin if (first_rd < 0) first_rd = rel; last_rd = rel; end
      if (mult_done_reg) begin if (first_md < 0) first_md = rel; last_md = rel; end
      if (done) done_rel = rel;
      if (busy) last_busy = rel;
      if (rel == 5) a5 = d_addr;
      if (rel == 66) al66 = d_al;
    end
    if (reset) begin
      busy_m = 1'b0; pc = 0; ps = 0;
    end else begin
      e_rd = 0; e_md = 0; e_done = 0; e_addr = 0; e_al = 0;
      if (busy_m) begin
        e_addr = (act < TOT) ? tup(act) : 0;
        if (!stall) begin
          e_rd   = (act < TOT);
          e_md   = (act >= PIPE) && (act < FIN);
          e_al   = e_md ? tup(act - PIPE) : 0;
          e_done = (act == FIN);
        end
      end
      chk("busy", busy, busy_m);
      chk("done", done, e_done);
      chk("rd_en", rd_en, e_rd);
      chk("mult_done_reg", mult_done_reg, e_md);
      chk("a_row_addr", a_row_addr, e_addr / 100);
      chk("b_col_addr", b_col_addr, (e_addr / 10) % 10);
      chk("a_col_addr", a_col_addr, e_addr % 10);
      chk("b_row_addr", b_row_addr, e_addr % 10);
      chk("al_a_row", al_a_row, e_al / 100);
      chk("al_b_col", al_b_col, (e_al / 10) % 10);
      chk("al_a_col", al_a_col, e_al % 10);
      chk("al_b_row", al_b_row, e_al % 10);
`ifdef MAC_STOP_SEQ_PERF_EN
      chk("perf_cycles", perf_cycles, pc);
      chk("perf_stalls", perf_stalls, ps);
`else
      chk("perf_cycles", perf_cycles, 0);
      chk("perf_stalls", perf_stalls, 0);
`endif
      if (busy_m) begin
        pc++;
        if (stall) ps++;
        else begin
          if (act == FIN) busy_m = 1'b0;
          act++;
        end
      end else if (start) begin
        busy_m = 1'b1; act = 0; pc = 0; ps = 0; start_cyc = cyc;
        done_rel = -1; first_rd = -1; last_rd = -1; first_md = -1; last_md = -1;
        last_busy = -1; a5 = -1; al66 = -1;
      end
    end
  end

  // mode: 0 no stall, 1 stall rel 10..12, 2 stall in DRAIN/DONE, 3 random stall and start pulses
  task automatic run_job(input int mode, input int restart_rel, input int reset_rel);
    bit fin;
    fin = 1'b0;
    for (int rel = 0; rel < 400 && !fin; rel++) begin
      @(posedge clk); #1;
      if (rel > 0 && !busy_m) begin
        fin = 1'b1; start = 1'b0; stall = 1'b0; reset = 1'b0;
      end else begin
        start = (rel == 0) || (rel == restart_rel) || (mode == 3 && $urandom_range(0, 15) == 0);
        reset = (rel == reset_rel);
        case (mode)
          1:       stall = (rel >= 10 && rel <= 12);
          2:       stall = (rel == 65 || rel == 68 || rel == 69);
          3:       stall = ($urandom_range(0, 3) == 0);
          default: stall = 1'b0;
        endcase
      end
    end
    chk("job_terminates", fin, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_job(0, -1, -1);
    chk("j1_first_rd", first_rd, 1);
    chk("j1_last_rd", last_rd, 64);
    chk("j1_first_md", first_md, 3);
    chk("j1_last_md", last_md, 66);
    chk("j1_done", done_rel, 67);
    chk("j1_last_busy", last_busy, 67);
    chk("j1_addr5", a5, 10);
    chk("j1_aligned66", al66, 333);

    run_job(1, -1, -1);
    chk("j2_done", done_rel, 70);
    chk("j2_last_rd", last_rd, 67);
`ifdef MAC_STOP_SEQ_PERF_EN
    chk("j2_perf_cycles", perf_cycles, 70);
    chk("j2_perf_stalls", perf_stalls, 3);
`endif

    run_job(0, 30, -1);
    chk("j3_done", done_rel, 67);

    run_job(0, -1, 20);
    chk("j4_no_done", done_rel, -1);
    chk("j4_last_busy", last_busy, 20);

    run_job(0, -1, -1);
    chk("j5_done", done_rel, 67);
    chk("j5_addr5", a5, 10);
    chk("j5_aligned66", al66, 333);

    run_job(2, -1, -1);
    chk("j6_done", done_rel, 70);

    for (int r = 0; r < 4; r++) run_job(3, -1, -1);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
